rhs_stim_sequencer: RTL and testbench
=====================================

Name: rhs_stim_sequencer

Overview:
- Parametrised biphasic stimulation pulse-train sequencer for the RHS stimulation path; successor to the fixed single-pair stim scheduler in the RHS AXI-Lite controller.
- Generalised channel count, timer widths, configurable interphase gap, cathodic/anodic-first ordering and monopolar/bipolar mode.
- Sits between the RHS AXI-Lite register bank (cfg inputs, start/stop) and the RHS SPI command builder (per-channel stim_on/stim_neg).
- Timing is in units of the external 50 us tick.

Parameters:
- NUM_CH, 32, number of stimulation channels; must be a power of two, 2..64.
- CH_W, $clog2(NUM_CH), width of the channel index fields.
- T_W, 16, width of the pulse-width, gap and delay fields, in ticks.
- N_W, 8, width of the pulse-count field.

Ports:
- aclk  in  1  single clock; rhs_aclk domain.
- areset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle strobe, one per 50 us time unit.
- start  in  1  one-cycle request to launch a train.
- stop  in  1  one-cycle abort request.
- cfg_bipolar  in  1  1 = bipolar (pos/neg pair), 0 = monopolar (pos only).
- cfg_anodic_first  in  1  1 = positive phase first.
- cfg_ch_pos  in  CH_W  positive electrode index.
- cfg_ch_neg  in  CH_W  negative electrode index.
- cfg_pw  in  T_W  phase width, in ticks.
- cfg_ipg  in  T_W  interphase gap, in ticks.
- cfg_ipd  in  T_W  interpulse delay, in ticks.
- cfg_npulse  in  N_W  pulse count minus one.
- stim_on  out  NUM_CH  per-channel stimulation enable.
- stim_neg  out  NUM_CH  per-channel current direction; 1 = sink.
- busy  out  1  a train is in progress.
- done  out  1  one-cycle pulse on normal train completion.
- aborted  out  1  one-cycle pulse when a train is ended by stop.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0.
- Config latch: all cfg_* are captured on the cycle start is accepted. Changes to cfg_* mid-train have no effect.
- start handling: accepted only in IDLE. start while busy is ignored.
- Zero-value clamping: cfg_pw = 0 is treated as 1. cfg_ipg = 0 skips GAP. cfg_ipd = 0 skips DELAY.
- Bipolar with cfg_ch_pos == cfg_ch_neg: behaves as monopolar.
- FSM states: IDLE, ARM, PH1, GAP, PH2, DELAY, (CR, optional feature only), FIN.
  - IDLE -> ARM on accepted start; busy=1 on the next cycle.
  - ARM -> PH1 on the next tick, so the first phase starts tick-aligned.
  - PH1 -> GAP after pw ticks, or -> PH2 if ipg = 0.
  - GAP -> PH2 after ipg ticks.
  - PH2 -> DELAY after pw ticks if pulses remain (ipd > 0).
  - PH2 -> PH1 after pw ticks if pulses remain and ipd = 0.
  - PH2 -> FIN after pw ticks on the last pulse.
  - DELAY -> PH1 after ipd ticks.
  - FIN: one cycle; asserts done, busy=0; -> IDLE.
- Counters:
  - The phase counter decrements only on tick. State changes on the tick that makes the count reach its terminal value.
  - The pulse counter loads cfg_npulse and decrements at the end of each PH2. The train ends when PH2 completes with the counter at 0.
  - cfg_npulse = 0 gives 1 pulse; the maximum 2^N_W-1 gives 2^N_W pulses.
- Output mapping (registered, 1-cycle latency from the state change):
  - PH1, cathodic-first: stim_on[pos]=1 with stim_neg[pos]=1. In bipolar, also stim_on[neg]=1 with stim_neg[neg]=0.
  - PH2, cathodic-first: same channels as PH1 with the stim_neg bits inverted.
  - Anodic-first: the PH1 and PH2 polarities are swapped.
  - All other states: stim_on=0, stim_neg=0.
- stop:
  - Accepted in any non-IDLE state.
  - On the next cycle: stim_on=0, stim_neg=0, aborted=1 for one cycle, busy=0, FSM -> IDLE. done is not asserted.
- Simultaneous events:
  - stop and start in IDLE: start wins; stop is ignored.
  - stop coinciding with the FIN cycle: done wins; aborted is not pulsed.
- Reset mid-train: all outputs drop to 0 on the next edge; no done or aborted pulse.
- Invariant: stim_on never has more than 2 bits set.

Optional Feature:
- Macro: RHS_STIM_CHARGE_RECOVERY_EN.
- When defined:
  - Adds input cfg_cr_len (T_W) and output charge_recov (NUM_CH).
  - After the last PH2 the FSM enters CR. charge_recov is asserted on the pos channel (and the neg channel in bipolar) for cfg_cr_len ticks, then FIN.
  - cfg_cr_len = 0 skips CR.
  - stop during CR clears charge_recov on the next cycle.
- When undefined: the port and the CR state are absent; PH2 (last pulse) -> FIN directly.

Test Plan:
- Bipolar, cathodic-first, pos=17, neg=18, pw=1, ipg=0, ipd=16, npulse=1, start:
  - Exactly 2 biphasic pulses.
  - stim_on = bits 17|18 for 2 ticks per pulse.
  - stim_neg[17] = 1 then 0 within each pulse.
  - 16 ticks idle between pulses; done pulses once; busy low after.
- Monopolar, anodic-first, pos=3, pw=4, ipg=2, npulse=0:
  - stim_on[3] high 4 ticks with stim_neg[3]=0, then 2 ticks off, then 4 ticks with stim_neg[3]=1.
  - No other stim_on bits ever set.
- stop asserted mid-GAP of pulse 3 of 8:
  - Next cycle: all outputs 0, aborted=1 for one cycle, done never asserted.
  - A subsequent start runs a full 8-pulse train.
- Reprogram cfg_pw from 2 to 9 mid-train: remaining pulses keep pw=2. start while busy: no restart, pulse count unchanged.
- Edge values:
  - pw=0 behaves as pw=1.
  - npulse=255 (N_W=8) yields 256 pulses.
  - pos=neg=5 in bipolar yields monopolar output on channel 5.
- With RHS_STIM_CHARGE_RECOVERY_EN defined, cr_len=3:
  - charge_recov[17] and [18] high 3 ticks after the last PH2, then done.
  - cr_len=0: done directly after PH2.

Source files
------------

// File: rtl/rhs_stim_sequencer.sv
// rhs_stim_sequencer: biphasic stimulation pulse-train sequencer for the RHS stim path.
//   Launches a train of cfg_npulse+1 biphasic pulses (PH1, optional GAP, PH2,
//   optional DELAY) timed in units of the external 50 us tick, driving per-channel
//   stim_on/stim_neg towards the RHS SPI command builder.
//   Ports: aclk/areset (sync, active-high); tick, start, stop strobes; cfg_* train
//   settings latched on start; stim_on/stim_neg per-channel drive; busy/done/aborted status.
//   Optional macro RHS_STIM_CHARGE_RECOVERY_EN adds cfg_cr_len and charge_recov
//   (a CR window after the last pulse).
module rhs_stim_sequencer #(
   parameter int NUM_CH = 32,
   parameter int CH_W   = $clog2(NUM_CH),
   parameter int T_W    = 16,
   parameter int N_W    = 8
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              tick,
   input  logic              start,
   input  logic              stop,
   input  logic              cfg_bipolar,
   input  logic              cfg_anodic_first,
   input  logic [CH_W-1:0]   cfg_ch_pos,
   input  logic [CH_W-1:0]   cfg_ch_neg,
   input  logic [T_W-1:0]    cfg_pw,
   input  logic [T_W-1:0]    cfg_ipg,
   input  logic [T_W-1:0]    cfg_ipd,
   input  logic [N_W-1:0]    cfg_npulse,
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
   input  logic [T_W-1:0]    cfg_cr_len,
   output logic [NUM_CH-1:0] charge_recov,
`endif
   output logic [NUM_CH-1:0] stim_on,
   output logic [NUM_CH-1:0] stim_neg,
   output logic              busy,
   output logic              done,
   output logic              aborted
);
   typedef enum logic [2:0] {
      IDLE, ARM, PH1, GAP, PH2, DELAY,
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
      CR,
`endif
      FIN
   } state_t;

   state_t            state_q;
   logic [T_W-1:0]    cnt_q, pw_q, ipg_q, ipd_q;
   logic [N_W-1:0]    pcnt_q;
   logic [CH_W-1:0]   pos_q, neg_q;
   logic              bip_q, anod_q;
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
   logic [T_W-1:0]    cr_q;
`endif

   logic              ph_end, in_ph, abort, pos_sink;
   logic [NUM_CH-1:0] pos_oh, neg_oh;

   always_comb begin
      ph_end   = tick && cnt_q == T_W'(1);
      in_ph    = state_q == PH1 || state_q == PH2;
      abort    = stop && !(state_q inside {IDLE, FIN});
      // cathodic-first PH1 sinks on the positive electrode; anodic-first flips both phases
      pos_sink = (state_q == PH1) ^ anod_q;
      pos_oh   = NUM_CH'(1) << pos_q;
      neg_oh   = bip_q ? NUM_CH'(1) << neg_q : '0;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         pcnt_q   <= '0;
         pw_q     <= '0;
         ipg_q    <= '0;
         ipd_q    <= '0;
         pos_q    <= '0;
         neg_q    <= '0;
         bip_q    <= 1'b0;
         anod_q   <= 1'b0;
         stim_on  <= '0;
         stim_neg <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         aborted  <= 1'b0;
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
         cr_q         <= '0;
         charge_recov <= '0;
`endif
      end else begin
         // outputs follow the state one cycle late; an abort forces them quiet at once
         stim_on  <= in_ph && !abort ? pos_oh | neg_oh : '0;
         stim_neg <= in_ph && !abort ? (pos_sink ? pos_oh : neg_oh) : '0;
         busy     <= !abort && !(state_q inside {IDLE, FIN});
         done     <= state_q == FIN;
         aborted  <= abort;
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
         charge_recov <= state_q == CR && !abort ? pos_oh | neg_oh : '0;
`endif
         // loads in the case below override this decrement on phase boundaries
         if (tick && cnt_q != '0) cnt_q <= cnt_q - T_W'(1);
         if (abort) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pcnt_q  <= '0;
         end else begin
            case (state_q)
               IDLE: if (start) begin
                  state_q <= ARM;
                  bip_q   <= cfg_bipolar && cfg_ch_pos != cfg_ch_neg;
                  anod_q  <= cfg_anodic_first;
                  pos_q   <= cfg_ch_pos;
                  neg_q   <= cfg_ch_neg;
                  pw_q    <= cfg_pw == '0 ? T_W'(1) : cfg_pw;
                  ipg_q   <= cfg_ipg;
                  ipd_q   <= cfg_ipd;
                  pcnt_q  <= cfg_npulse;
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
                  cr_q    <= cfg_cr_len;
`endif
               end
               ARM: if (tick) begin
                  state_q <= PH1;
                  cnt_q   <= pw_q;
               end
               PH1: if (ph_end) begin
                  state_q <= ipg_q != '0 ? GAP : PH2;
                  cnt_q   <= ipg_q != '0 ? ipg_q : pw_q;
               end
               GAP: if (ph_end) begin
                  state_q <= PH2;
                  cnt_q   <= pw_q;
               end
               PH2: if (ph_end) begin
                  if (pcnt_q == '0) begin
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
                     state_q <= cr_q != '0 ? CR : FIN;
                     cnt_q   <= cr_q;
`else
                     state_q <= FIN;
`endif
                  end else begin
                     pcnt_q  <= pcnt_q - N_W'(1);
                     state_q <= ipd_q != '0 ? DELAY : PH1;
                     cnt_q   <= ipd_q != '0 ? ipd_q : pw_q;
                  end
               end
               DELAY: if (ph_end) begin
                  state_q <= PH1;
                  cnt_q   <= pw_q;
               end
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
               CR: if (ph_end) state_q <= FIN;
`endif
               FIN: state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_rhs_stim_sequencer.sv
// tb_rhs_stim_sequencer: directed bench for rhs_stim_sequencer with a tick-schedule reference model.
module tb_rhs_stim_sequencer;
   localparam int NUM_CH = 32, CH_W = 5, T_W = 16, N_W = 8;
   localparam int C_IDLE = 0, C_ARM = 1, C_OFF = 2, C_PH1 = 3, C_PH2 = 4, C_CR = 5, C_FIN = 6;

   logic clk = 0, rst = 1, tick = 0, start = 0, stop = 0, bip = 0, anod = 0;
   logic [CH_W-1:0] pos = 0, neg = 0;
   logic [T_W-1:0] pw = 0, ipg = 0, ipd = 0, cr_len = 0;
   logic [N_W-1:0] np = 0;
   logic [NUM_CH-1:0] stim_on, stim_neg, charge_recov;
   logic busy, done, aborted;

   int passed = 0, total = 0;
   int tper = 1, tcnt = 0;
   bit cmp_en = 0;

   always #5 clk = ~clk;

   rhs_stim_sequencer #(.NUM_CH(NUM_CH), .CH_W(CH_W), .T_W(T_W), .N_W(N_W)) dut (
      .aclk(clk), .areset(rst), .tick(tick), .start(start), .stop(stop),
      .cfg_bipolar(bip), .cfg_anodic_first(anod), .cfg_ch_pos(pos), .cfg_ch_neg(neg),
      .cfg_pw(pw), .cfg_ipg(ipg), .cfg_ipd(ipd), .cfg_npulse(np),
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
      .cfg_cr_len(cr_len), .charge_recov(charge_recov),
`endif
      .stim_on(stim_on), .stim_neg(stim_neg), .busy(busy), .done(done), .aborted(aborted)
   );
`ifndef RHS_STIM_CHARGE_RECOVERY_EN
   assign charge_recov = '0;
`endif

   // reference model: where a train stands is derived purely from how many ticks
   // have elapsed since start, using the pulse period arithmetic
   int m_cls = C_IDLE, m_k = 0, m_pw = 1, m_ipg = 0, m_ipd = 0, m_n = 1, m_cr = 0, m_pos = 0, m_neg = 0;
   bit m_bip = 0, m_anod = 0;
   logic [NUM_CH-1:0] e_on = 0, e_neg = 0, e_cr = 0, m_pos_oh, m_neg_oh;
   logic e_busy = 0, e_done = 0, e_abort = 0;
   wire m_ph = m_cls == C_PH1 || m_cls == C_PH2;
   wire m_pos_sinks = (m_cls == C_PH1) != m_anod;
   wire m_stop = stop && m_cls != C_IDLE && m_cls != C_FIN;
   assign m_pos_oh = NUM_CH'(1) << m_pos;
   assign m_neg_oh = (m_bip && m_pos != m_neg) ? NUM_CH'(1) << m_neg : '0;

   function automatic int classify(int t, int w, int g, int d, int n, int c);
      int l = 2 * w + g + d;
      int te = n * l - d;
      int o = t % l;
      if (t >= te) return (t < te + c) ? C_CR : C_FIN;
      if (o < w) return C_PH1;
      if (o < w + g) return C_OFF;
      if (o < 2 * w + g) return C_PH2;
      return C_OFF;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_cls <= C_IDLE; m_k <= 0;
         e_on <= '0; e_neg <= '0; e_cr <= '0; e_busy <= 0; e_done <= 0; e_abort <= 0;
      end else begin
         e_on    <= (!m_stop && m_ph) ? m_pos_oh | m_neg_oh : '0;
         e_neg   <= (!m_stop && m_ph) ? (m_pos_sinks ? m_pos_oh : m_neg_oh) : '0;
         e_cr    <= (!m_stop && m_cls == C_CR) ? m_pos_oh | m_neg_oh : '0;
         e_busy  <= !m_stop && m_cls != C_IDLE && m_cls != C_FIN;
         e_done  <= m_cls == C_FIN;
         e_abort <= m_stop;
         if (m_stop || m_cls == C_FIN) m_cls <= C_IDLE;
         else if (m_cls == C_IDLE) begin
            if (start) begin
               m_cls <= C_ARM; m_k <= 0;
               m_bip <= bip; m_anod <= anod; m_pos <= int'(pos); m_neg <= int'(neg);
               m_pw <= pw == 0 ? 1 : int'(pw); m_ipg <= int'(ipg); m_ipd <= int'(ipd);
               m_n <= int'(np) + 1;
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
               m_cr <= int'(cr_len);
`else
               m_cr <= 0;
`endif
            end
         end else if (tick) begin
            m_k <= m_k + 1;
            m_cls <= classify(m_k, m_pw, m_ipg, m_ipd, m_n, m_cr);
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      total++;
      if (a === e) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
   endtask

   // per-test observation counters
   int rises, on_cyc, neg_cyc, done_cnt, abort_cnt, last_gap, cur_gap, pop_max, foreign, cr_cyc;
   bit seen_on, prev_on;
   logic [NUM_CH-1:0] allow = '1;

   task automatic clr(input logic [NUM_CH-1:0] a);
      rises = 0; on_cyc = 0; neg_cyc = 0; done_cnt = 0; abort_cnt = 0; last_gap = 0;
      cur_gap = 0; pop_max = 0; foreign = 0; cr_cyc = 0; seen_on = 0; allow = a;
   endtask

   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         chk("stim_on", stim_on, e_on);
         chk("stim_neg", stim_neg, e_neg);
         chk("busy", busy, e_busy);
         chk("done", done, e_done);
         chk("aborted", aborted, e_abort);
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
         chk("charge_recov", charge_recov, e_cr);
`endif
         if (stim_on != 0 && !prev_on) begin
            rises++;
            if (seen_on) last_gap = cur_gap;
         end
         if (stim_on != 0) begin on_cyc++; cur_gap = 0; seen_on = 1; end
         else cur_gap++;
         if (stim_neg != 0) neg_cyc++;
         if (charge_recov != 0) cr_cyc++;
         if (done) done_cnt++;
         if (aborted) abort_cnt++;
         if ((stim_on & ~allow) != 0) foreign++;
         if ($countones(stim_on) > pop_max) pop_max = $countones(stim_on);
         prev_on = stim_on != 0;
      end
   end

   initial forever begin
      @(posedge clk);
      #1 tcnt++;
      tick = (tcnt % tper) == 0;
   end

   task automatic cfg(input logic b, input logic a, input int p, input int n, input int w,
                      input int g, input int d, input int k, input int tp);
      bip = b; anod = a; pos = CH_W'(p); neg = CH_W'(n); pw = T_W'(w); ipg = T_W'(g);
      ipd = T_W'(d); np = N_W'(k); tper = tp;
   endtask

   task automatic go();
      start = 1;
      @(posedge clk);
      #1 start = 0;
   endtask

   task automatic wait_end(input int budget, input string nm);
      int n = 0;
      while (!done && !aborted && n < budget) begin
         @(posedge clk);
         #1 n++;
      end
      chk({nm, " timeout"}, n >= budget, 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_rises(input int r);
      int n = 0;
      while (rises < r && n < 2000) begin
         @(posedge clk);
         #1 n++;
      end
      chk("rise wait timeout", n >= 2000, 0);
   endtask

   initial begin
      clr('1);
      repeat (3) @(posedge clk);
      #1 rst = 0;
      cmp_en = 1;
      chk("rst stim_on", stim_on, 0);
      chk("rst stim_neg", stim_neg, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst aborted", aborted, 0);

      // bipolar cathodic-first 17/18, two pulses separated by 16 ticks
      clr(32'h0006_0000);
      cfg(1, 0, 17, 18, 1, 0, 16, 1, 1);
      go();
      wait_end(500, "t1");
      chk("t1 rises", rises, 2);
      chk("t1 on cycles", on_cyc, 4);
      chk("t1 neg cycles", neg_cyc, 4);
      chk("t1 gap", last_gap, 16);
      chk("t1 done", done_cnt, 1);
      chk("t1 aborted", abort_cnt, 0);
      chk("t1 pop", pop_max, 2);
      chk("t1 foreign", foreign, 0);
      chk("t1 busy after", busy, 0);

      // monopolar anodic-first ch3, pw=4 ipg=2 single pulse
      clr(32'h0000_0008);
      cfg(0, 1, 3, 7, 4, 2, 0, 0, 1);
      go();
      wait_end(500, "t2");
      chk("t2 rises", rises, 2);
      chk("t2 on cycles", on_cyc, 8);
      chk("t2 neg cycles", neg_cyc, 4);
      chk("t2 gap", last_gap, 2);
      chk("t2 foreign", foreign, 0);
      chk("t2 done", done_cnt, 1);

      // stop in the gap of pulse 3 of 8, then a full rerun
      clr(32'h0000_0006);
      cfg(1, 0, 1, 2, 2, 3, 2, 7, 1);
      go();
      wait_rises(5);
      while (stim_on != 0) begin
         @(posedge clk);
         #1;
      end
      stop = 1;
      @(posedge clk);
      #1 stop = 0;
      chk("t3 aborted", aborted, 1);
      chk("t3 stim_on", stim_on, 0);
      chk("t3 busy", busy, 0);
      @(posedge clk);
      #1 chk("t3 aborted drop", aborted, 0);
      repeat (3) @(posedge clk);
      #1 chk("t3 done", done_cnt, 0);
      chk("t3 abort cnt", abort_cnt, 1);
      clr(32'h0000_0006);
      go();
      wait_end(1000, "t3b");
      chk("t3b rises", rises, 16);
      chk("t3b on cycles", on_cyc, 32);
      chk("t3b done", done_cnt, 1);

      // mid-train cfg change and start while busy are ignored
      clr(32'h0000_0200);
      cfg(0, 0, 9, 0, 2, 0, 1, 3, 3);
      go();
      repeat (20) @(posedge clk);
      #1 pw = 9;
      go();
      wait_end(1000, "t4");
      chk("t4 rises", rises, 4);
      chk("t4 on cycles", on_cyc, 48);
      chk("t4 done", done_cnt, 1);

      // pw=0 behaves as pw=1
      clr(32'h0000_0001);
      cfg(0, 0, 0, 0, 0, 0, 0, 0, 1);
      go();
      wait_end(200, "t5");
      chk("t5 on cycles", on_cyc, 2);
      chk("t5 rises", rises, 1);
      chk("t5 neg cycles", neg_cyc, 1);

      // npulse=255 gives 256 pulses
      clr(32'h8000_0000);
      cfg(0, 0, 31, 0, 1, 0, 1, 255, 1);
      go();
      wait_end(3000, "t6");
      chk("t6 rises", rises, 256);
      chk("t6 on cycles", on_cyc, 512);
      chk("t6 done", done_cnt, 1);

      // bipolar with pos==neg collapses to monopolar on ch5
      clr(32'h0000_0020);
      cfg(1, 0, 5, 5, 2, 1, 0, 1, 1);
      go();
      wait_end(500, "t7");
      chk("t7 foreign", foreign, 0);
      chk("t7 pop", pop_max, 1);
      chk("t7 on cycles", on_cyc, 8);

      // reset mid-train
      clr('1);
      cfg(1, 1, 10, 11, 3, 1, 2, 4, 1);
      go();
      repeat (6) @(posedge clk);
      #1 rst = 1;
      @(posedge clk);
      #1 rst = 0;
      chk("t8 stim_on", stim_on, 0);
      chk("t8 busy", busy, 0);
      repeat (5) @(posedge clk);
      #1 chk("t8 done", done_cnt, 0);
      chk("t8 aborted", abort_cnt, 0);

      // start+stop together in IDLE, then stop landing on the FIN cycle
      clr('1);
      cfg(0, 0, 4, 0, 1, 0, 0, 0, 1);
      start = 1; stop = 1;
      @(posedge clk);
      #1 start = 0; stop = 0;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #1 stop = 1;
      @(posedge clk);
      #1 stop = 0;
      chk("t9 done", done, 1);
      chk("t9 aborted", aborted, 0);
      repeat (2) @(posedge clk);
      #1 chk("t9 abort cnt", abort_cnt, 0);
      chk("t9 done cnt", done_cnt, 1);

`ifdef RHS_STIM_CHARGE_RECOVERY_EN
      clr(32'h0006_0000);
      cr_len = 3;
      cfg(1, 0, 17, 18, 1, 0, 16, 1, 1);
      go();
      wait_end(500, "t10");
      chk("t10 cr cycles", cr_cyc, 3);
      chk("t10 done", done_cnt, 1);
      clr(32'h0006_0000);
      cr_len = 0;
      go();
      wait_end(500, "t10b");
      chk("t10b cr cycles", cr_cyc, 0);
      chk("t10b done", done_cnt, 1);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
